// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: instruction memory geometry, word packing width and FSM states.
package imem_loader_pkg;
  localparam int IMEM_DEPTH     = 64;
  localparam int IMEM_ADDR_W    = 6;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ld_state_e;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port seen by the loader.
interface imem_loader_if import imem_loader_pkg::*; #(
  parameter int ADDR_W = IMEM_ADDR_W
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // master = loader side, slave = byte source / memory side
  modport master (input rx_valid, rx_data, output rx_ready, wr_en, wr_addr, wr_data);
  modport slave  (output rx_valid, rx_data, input rx_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into a 32-bit word; first byte ends up in the LSB.
module imem_loader_byte_packer import imem_loader_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);
  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane;
  logic [31:0]       word_q;

  // Shifting in from the top leaves byte k at [8k+7:8k] once the word is complete.
  assign word_next = {byte_in, word_q[31:8]};
  assign word_full = shift_en && (lane == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane   <= '0;
      word_q <= '0;
    end else if (shift_en) begin
      lane   <= lane + 1'b1;
      word_q <= word_next;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a byte stream, holding the core in reset until done.
module imem_loader import imem_loader_pkg::*; #(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int DEPTH   = IMEM_DEPTH,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  imem_loader_if.master     bus,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  ld_state_e         state;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_sat;
  logic [TO_W-1:0]   to_cnt;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              err_q;
  logic              accept;
  logic              pk_full;
  logic [31:0]       pk_next;

  assign len_sat = (load_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : load_len;
  assign accept  = bus.rx_valid && (state == RECV);

  // Partial word is dropped whenever the FSM is outside RECV.
  imem_loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state != RECV),
    .shift_en  (accept),
    .byte_in   (bus.rx_data),
    .word_next (pk_next),
    .word_full (pk_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word_idx  <= '0;
      len_q     <= '0;
      to_cnt    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load_start) begin
            err_q    <= 1'b0;
            len_q    <= len_sat;
            word_idx <= '0;
            to_cnt   <= '0;
            state    <= (len_sat == '0) ? DONE : RECV;
          end
        end
        RECV: begin
          if (accept) begin
            to_cnt <= '0;
            if (pk_full) begin
              wr_addr_q <= word_idx;
              wr_data_q <= pk_next;
              state     <= WRITE;
            end
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            to_cnt <= '0;
            err_q  <= 1'b1;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WRITE: begin
          to_cnt <= '0;
          if ({1'b0, word_idx} == len_q - (ADDR_W+1)'(1)) begin
            state <= DONE;
          end else begin
            word_idx <= word_idx + 1'b1;
            state    <= RECV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_ready = (state == RECV);
  assign bus.wr_en    = (state == WRITE);
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cpu_rst      = (state != DONE);
  assign busy         = (state == RECV) || (state == WRITE);
  assign done         = (state == DONE);
  assign err          = err_q;
endmodule
